// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_pkg
// Brief   : Shared constants, state encoding and response helper for the
//           UART command responder.
// Rev     : 1.0  initial release
// ============================================================================
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;

    localparam logic [1:0] OP_WRITE       = 2'b00;
    localparam logic [1:0] OP_READ        = 2'b01;
    localparam logic [1:0] OP_ECHO        = 2'b10;
    localparam logic [1:0] OP_INVALID     = 2'b11;

    localparam logic [7:0] STATUS_OK      = 8'h00;
    localparam logic [7:0] STATUS_CHK_ERR = 8'hE1;
    localparam logic [7:0] STATUS_BAD_OP  = 8'hE2;

    localparam int         RESP_LEN       = 4;

    typedef enum logic [2:0] {
        ST_HUNT     = 3'd0,
        ST_GET_CMD  = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_GET_CHK  = 3'd3,
        ST_EXEC     = 3'd4,
        ST_SEND     = 3'd5
    } state_t;

    // Response layout: SYNC, STATUS, RDATA, STATUS^RDATA.
    function automatic logic [7:0] resp_byte(
        input logic [1:0] idx,
        input logic [7:0] status,
        input logic [7:0] rdata
    );
        logic [7:0] b;
        unique case (idx)
            2'd0:    b = SYNC_BYTE;
            2'd1:    b = status;
            2'd2:    b = rdata;
            default: b = status ^ rdata;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_regfile.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_regfile
// Brief   : Small register file, one write port, one asynchronous read port,
//           full contents exposed as a flat vector.
// Rev     : 1.0  initial release
// ============================================================================
module uart_cmd_regfile
    import uart_cmd_pkg::*;
#(
    parameter int DBIT  = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DBIT-1:0]       wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DBIT-1:0]       rdata,
    output logic [DEPTH*DBIT-1:0] regs
);

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_reg
            logic [DBIT-1:0] word_q;
            logic [DBIT-1:0] word_d;

            always_comb begin
                word_d = word_q;
                if (we && (waddr == AW'(i))) begin
                    word_d = wdata;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign regs[i*DBIT +: DBIT] = word_q;
        end
    endgenerate

    assign rdata = regs[int'(raddr)*DBIT +: DBIT];

endmodule
`default_nettype wire

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_responder
// Brief   : Parses 4-byte command frames from a UART RX FIFO, executes them
//           on a 4x8 register file and returns a 4-byte response.
// Rev     : 1.0  initial release
// ============================================================================
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [DBIT-1:0]   r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [DBIT-1:0]   w_data,
    output logic              wr_uart,
    output logic [4*DBIT-1:0] reg_q,
    output logic              busy,
    output logic              frame_ok,
    output logic [7:0]        err_cnt
);

    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TOUT_LIMIT = TW'(TIMEOUT);
    localparam logic [1:0]    LAST_IDX   = 2'(RESP_LEN - 1);

    state_t          state_q,    state_d;
    logic [DBIT-1:0] cmd_q,      cmd_d;
    logic [DBIT-1:0] data_q,     data_d;
    logic [DBIT-1:0] chk_q,      chk_d;
    logic [7:0]      status_q,   status_d;
    logic [DBIT-1:0] rdata_q,    rdata_d;
    logic [1:0]      idx_q,      idx_d;
    logic [TW-1:0]   tout_q,     tout_d;
    logic            rd_uart_q,  rd_uart_d;
    logic            wr_uart_q,  wr_uart_d;
    logic [DBIT-1:0] w_data_q,   w_data_d;
    logic            frame_ok_q, frame_ok_d;
    logic [7:0]      err_cnt_q,  err_cnt_d;

    logic            err_inc;
    logic            rf_we;
    logic [DBIT-1:0] rf_rdata;
    logic            chk_ok;
    logic [1:0]      op;

    assign op     = cmd_q[7:6];
    assign chk_ok = ((cmd_q ^ data_q) == chk_q);

    uart_cmd_regfile #(
        .DBIT  (DBIT),
        .DEPTH (4)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (rf_we),
        .waddr (cmd_q[1:0]),
        .wdata (data_q),
        .raddr (cmd_q[1:0]),
        .rdata (rf_rdata),
        .regs  (reg_q)
    );

    // rd_uart is registered, so a pop is requested one cycle and performed
    // (with r_data sampled) the next; a new request is never issued while
    // one is in flight, otherwise the stale FWFT head would be read twice.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        chk_d      = chk_q;
        status_d   = status_q;
        rdata_d    = rdata_q;
        idx_d      = idx_q;
        tout_d     = tout_q;
        rd_uart_d  = 1'b0;
        wr_uart_d  = 1'b0;
        w_data_d   = w_data_q;
        frame_ok_d = 1'b0;
        err_inc    = 1'b0;
        rf_we      = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                tout_d = '0;
                if (rd_uart_q) begin
                    if (r_data == SYNC_BYTE) begin
                        state_d = ST_GET_CMD;
                    end
                end else if (!rx_empty) begin
                    rd_uart_d = 1'b1;
                end
            end

            ST_GET_CMD, ST_GET_DATA, ST_GET_CHK: begin
                if (rd_uart_q) begin
                    tout_d = '0;
                    if (state_q == ST_GET_CMD) begin
                        cmd_d   = r_data;
                        state_d = ST_GET_DATA;
                    end else if (state_q == ST_GET_DATA) begin
                        data_d  = r_data;
                        state_d = ST_GET_CHK;
                    end else begin
                        chk_d   = r_data;
                        state_d = ST_EXEC;
                    end
                end else if (tout_q == TOUT_LIMIT) begin
                    tout_d  = '0;
                    err_inc = 1'b1;
                    state_d = ST_HUNT;
                end else if (!rx_empty) begin
                    rd_uart_d = 1'b1;
                end else begin
                    tout_d = tout_q + TW'(1);
                end
            end

            ST_EXEC: begin
                idx_d   = '0;
                state_d = ST_SEND;
                // Checksum failure outranks an invalid opcode.
                if (!chk_ok) begin
                    status_d = STATUS_CHK_ERR;
                    rdata_d  = '0;
                    err_inc  = 1'b1;
                end else if (op == OP_INVALID) begin
                    status_d = STATUS_BAD_OP;
                    rdata_d  = '0;
                    err_inc  = 1'b1;
                end else begin
                    status_d   = STATUS_OK;
                    rdata_d    = (op == OP_READ) ? rf_rdata : data_q;
                    rf_we      = (op == OP_WRITE);
                    frame_ok_d = 1'b1;
                end
            end

            ST_SEND: begin
                if (!tx_full) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = resp_byte(idx_q, status_q, rdata_q);
                    idx_d     = idx_q + 2'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_HUNT;
                    end
                end
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase

        err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HUNT;
            cmd_q      <= '0;
            data_q     <= '0;
            chk_q      <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            idx_q      <= '0;
            tout_q     <= '0;
            rd_uart_q  <= 1'b0;
            wr_uart_q  <= 1'b0;
            w_data_q   <= '0;
            frame_ok_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            chk_q      <= chk_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            idx_q      <= idx_d;
            tout_q     <= tout_d;
            rd_uart_q  <= rd_uart_d;
            wr_uart_q  <= wr_uart_d;
            w_data_q   <= w_data_d;
            frame_ok_q <= frame_ok_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rd_uart  = rd_uart_q;
    assign wr_uart  = wr_uart_q;
    assign w_data   = w_data_q;
    assign frame_ok = frame_ok_q;
    assign err_cnt  = err_cnt_q;
    assign busy     = (state_q != ST_HUNT);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_cmd_responder
// Brief   : Self-checking bench: directed frame table, corner sequences and
//           randomized frames against a byte-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_cmd_responder;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        tx_full;
    logic        rd_uart, wr_uart, busy, frame_ok;
    logic [7:0]  w_data, err_cnt;
    logic [31:0] reg_q;

    logic tx_hold = 1'b0, bp_rand = 1'b0, rnd_bit = 1'b0;
    assign tx_full = tx_hold | (bp_rand & rnd_bit);

    always #5 clk = ~clk;

    uart_cmd_responder #(.DBIT(8), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .rd_uart  (rd_uart),
        .tx_full  (tx_full),
        .w_data   (w_data),
        .wr_uart  (wr_uart),
        .reg_q    (reg_q),
        .busy     (busy),
        .frame_ok (frame_ok),
        .err_cnt  (err_cnt)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fok_cnt = 0;
    int rd_seen = 0;
    logic pop_pending = 1'b0;
    logic tx_full_at_edge = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];

    logic [7:0] m_regs[4];
    int         m_err = 0;
    int         m_fok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FWFT RX FIFO and TX sink, updated clear of the DUT's sampling edge.
    always @(negedge clk) rnd_bit = ($urandom_range(0, 2) == 0);

    always @(posedge clk) begin
        cyc++;
        tx_full_at_edge = tx_full;
        #1;
        if (!reset) rx_q.delete();
        else if (pop_pending && rx_q.size() > 0) void'(rx_q.pop_front());
        pop_pending = 1'b0;
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? 8'h00 : rx_q[0];
    end

    always @(negedge clk) begin
        pop_pending = rd_uart;
        if (rd_uart) rd_seen++;
        if (frame_ok) fok_cnt++;
        if (wr_uart) begin
            tx_log.push_back(w_data);
            tx_cyc.push_back(cyc);
            chk("push_while_full", {31'd0, tx_full_at_edge}, 32'd0);
        end
        if (rd_uart || wr_uart) chk("rd_wr_overlap", {31'd0, rd_uart & wr_uart}, 32'd0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: response and side effects computed from the frame rules.
    task automatic model_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k,
                               output logic [7:0] st, output logic [7:0] rd);
        if ((c ^ d) != k) begin
            st = 8'hE1; rd = 8'h00;
        end else if (c[7:6] == 2'b11) begin
            st = 8'hE2; rd = 8'h00;
        end else begin
            st = 8'h00;
            case (c[7:6])
                2'b00:   begin m_regs[c[1:0]] = d; rd = d; end
                2'b01:   rd = m_regs[c[1:0]];
                default: rd = d;
            endcase
            m_fok++;
        end
        if (st != 8'h00 && m_err < 255) m_err++;
    endtask

    function automatic logic [31:0] m_pack();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k, input int gap);
        logic [7:0] bytes[4];
        bytes[0] = 8'hA5; bytes[1] = c; bytes[2] = d; bytes[3] = k;
        for (int i = 0; i < 4; i++) begin
            rx_q.push_back(bytes[i]);
            repeat ($urandom_range(0, gap)) tick();
        end
    endtask

    task automatic wait_tx(input string tag, input int n, input int limit);
        int k = 0;
        while (tx_log.size() < n && k < limit) begin tick(); k++; end
        if (tx_log.size() < n) chk({tag, "_tx_timeout"}, tx_log.size(), n);
    endtask

    task automatic wait_rx_drain(input string tag);
        int k = 0;
        while (rx_q.size() != 0 && k < 200) begin tick(); k++; end
        if (rx_q.size() != 0) chk({tag, "_rx_timeout"}, rx_q.size(), 0);
    endtask

    task automatic expect_resp(input string tag, input int base, input logic [7:0] st, input logic [7:0] rd);
        logic [7:0] exp[4];
        logic [7:0] act;
        exp[0] = 8'hA5; exp[1] = st; exp[2] = rd; exp[3] = st ^ rd;
        wait_tx(tag, base + 4, 300);
        for (int j = 0; j < 4; j++) begin
            act = (base + j < tx_log.size()) ? tx_log[base + j] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, j), act, exp[j]);
        end
        repeat (3) tick();
    endtask

    task automatic model_run(input string tag, input logic [7:0] c, input logic [7:0] d,
                             input logic [7:0] k, input int gap);
        int base, f0, mf0;
        logic [7:0] st, rd;
        base = tx_log.size(); f0 = fok_cnt; mf0 = m_fok;
        model_frame(c, d, k, st, rd);
        send_frame(c, d, k, gap);
        expect_resp(tag, base, st, rd);
        chk({tag, "_fok"}, fok_cnt - f0, m_fok - mf0);
        chk({tag, "_regs"}, reg_q, m_pack());
        chk({tag, "_err"}, {24'd0, err_cnt}, m_err);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd"}, {31'd0, rd_uart}, 0);
        chk({tag, "_wr"}, {31'd0, wr_uart}, 0);
        chk({tag, "_wdata"}, {24'd0, w_data}, 0);
        chk({tag, "_regs"}, reg_q, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_fok"}, {31'd0, frame_ok}, 0);
        chk({tag, "_err"}, {24'd0, err_cnt}, 0);
    endtask

    typedef struct {
        logic [7:0]  cmd, data, chk_b, st, rd;
        logic [31:0] regs;
        int          err, fok;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int base, f0, rd0;
        logic [7:0] st, rd, j;

        tbl[0] = '{8'h02, 8'h3C, 8'h3E, 8'h00, 8'h3C, 32'h003C0000, 0, 1};
        tbl[1] = '{8'h42, 8'h00, 8'h42, 8'h00, 8'h3C, 32'h003C0000, 0, 1};
        tbl[2] = '{8'h02, 8'h3C, 8'h00, 8'hE1, 8'h00, 32'h003C0000, 1, 0};
        tbl[3] = '{8'hC0, 8'h11, 8'hD1, 8'hE2, 8'h00, 32'h003C0000, 2, 0};
        tbl[4] = '{8'hC3, 8'h11, 8'h00, 8'hE1, 8'h00, 32'h003C0000, 3, 0};
        tbl[5] = '{8'h3C, 8'h77, 8'h4B, 8'h00, 8'h77, 32'h003C0077, 3, 1};
        tbl[6] = '{8'h81, 8'h5A, 8'hDB, 8'h00, 8'h5A, 32'h003C0077, 3, 1};
        tbl[7] = '{8'h43, 8'h00, 8'h43, 8'h00, 8'h00, 32'h003C0077, 3, 1};
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

        repeat (3) tick();
        check_reset_vals("por");
        reset = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 8; i++) begin
            base = tx_log.size(); f0 = fok_cnt;
            model_frame(tbl[i].cmd, tbl[i].data, tbl[i].chk_b, st, rd);
            send_frame(tbl[i].cmd, tbl[i].data, tbl[i].chk_b, 0);
            expect_resp($sformatf("tbl%0d", i), base, tbl[i].st, tbl[i].rd);
            chk($sformatf("tbl%0d_regs", i), reg_q, tbl[i].regs);
            chk($sformatf("tbl%0d_err", i), {24'd0, err_cnt}, tbl[i].err);
            chk($sformatf("tbl%0d_fok", i), fok_cnt - f0, tbl[i].fok);
        end

        // Junk bytes then a truncated frame that must time out silently.
        rx_q.push_back(8'h00); rx_q.push_back(8'hFF);
        rx_q.push_back(8'hA5); rx_q.push_back(8'h02);
        wait_rx_drain("tmo");
        base = tx_log.size();
        repeat (TO - 5) tick();
        chk("tmo_busy_before", {31'd0, busy}, 1);
        repeat (30) tick();
        chk("tmo_busy_after", {31'd0, busy}, 0);
        chk("tmo_no_tx", tx_log.size(), base);
        if (m_err < 255) m_err++;
        chk("tmo_err", {24'd0, err_cnt}, m_err);
        model_run("post_tmo", 8'h81, 8'h5A, 8'hDB, 0);

        // Backpressure held across EXEC and SEND, extra RX byte pending.
        tx_hold = 1'b1;
        base = tx_log.size();
        model_frame(8'h40, 8'h00, 8'h40, st, rd);
        send_frame(8'h40, 8'h00, 8'h40, 0);
        wait_rx_drain("bp");
        repeat (2) tick();
        rx_q.push_back(8'h11);
        rd0 = rd_seen;
        repeat (10) tick();
        chk("bp_no_tx", tx_log.size(), base);
        chk("bp_no_rd", rd_seen, rd0);
        chk("bp_rx_kept", rx_q.size(), 1);
        chk("bp_busy", {31'd0, busy}, 1);
        tx_hold = 1'b0;
        expect_resp("bp", base, st, rd);
        if (tx_cyc.size() >= base + 4) chk("bp_consecutive", tx_cyc[base + 3] - tx_cyc[base], 3);
        else chk("bp_consecutive_missing", tx_cyc.size(), base + 4);

        // Reset in the middle of a response.
        base = tx_log.size();
        send_frame(8'h02, 8'h55, 8'h57, 0);
        wait_tx("rst", base + 1, 300);
        reset = 1'b0;
        #1;
        check_reset_vals("rst_mid_send");
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_err = 0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (10) tick();
        chk("rst_no_resume", tx_log.size(), base + 1);
        model_run("post_rst", 8'h01, 8'h99, 8'h98, 0);

        // Randomized frames with junk prefix, byte gaps and TX backpressure.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] c, d, k;
            bp_rand = $urandom_range(0, 1);
            repeat ($urandom_range(0, 2)) begin
                do j = 8'($urandom); while (j == 8'hA5);
                rx_q.push_back(j);
            end
            c = 8'($urandom); d = 8'($urandom);
            k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (c ^ d);
            model_run($sformatf("rnd%0d", n), c, d, k, 4);
        end
        bp_rand = 1'b0;

        // Drive the error counter into saturation.
        while (m_err < 255) model_run("sat", 8'h00, 8'h00, 8'h01, 0);
        model_run("sat_hold", 8'h00, 8'h00, 8'h01, 0);
        chk("sat_value", {24'd0, err_cnt}, 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 Parameter DBIT, default 8, byte width of the UART FIFO interface.
REQ-002 Parameter TIMEOUT, default 100000, maximum clk cycles allowed between bytes within one frame.
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port reset  in  1  reset, asynchronous, active-low.
REQ-005 Port rx_empty  in  1  UART RX FIFO empty flag.
REQ-006 Port r_data  in  8  UART RX FIFO head word, first-word-fall-through.
REQ-007 Port rd_uart  out  1  one-cycle pop of the RX FIFO head.
REQ-008 Port tx_full  in  1  UART TX FIFO full flag.
REQ-009 Port w_data  out  8  byte pushed to the TX FIFO.
REQ-010 Port wr_uart  out  1  one-cycle push of w_data into the TX FIFO.
REQ-011 Port reg_q  out  32  register file contents, reg[n] at bits 8n+7:8n.
REQ-012 Port busy  out  1  high in every state except HUNT.
REQ-013 Port frame_ok  out  1  one-cycle pulse when a valid frame executes.
REQ-014 Port err_cnt  out  8  saturating count of frame errors.

Function
REQ-015 Request frame SHALL be 4 bytes: SYNC=0xA5, CMD, DATA, CHK; CMD[7:6]=op, CMD[1:0]=addr, CMD[5:2] ignored; CHK=CMD^DATA.
REQ-016 Ops SHALL be: 00 write reg[addr]=DATA; 01 read reg[addr]; 10 echo DATA; 11 invalid.
REQ-017 Response SHALL be 4 bytes: 0xA5, STATUS, RDATA, STATUS^RDATA.
REQ-018 STATUS SHALL be 0x00 ok, 0xE1 checksum error, 0xE2 invalid op; a checksum error takes priority over an invalid op.
REQ-019 RDATA SHALL be: write -> DATA; read -> reg[addr]; echo -> DATA; any error -> 0x00.
REQ-020 States SHALL be HUNT, GET_CMD, GET_DATA, GET_CHK, EXEC, SEND.
REQ-021 A byte SHALL be consumed only when rx_empty=0; in that cycle rd_uart=1 and r_data is sampled.
REQ-022 In HUNT, non-0xA5 bytes SHALL be popped and discarded; 0xA5 advances to GET_CMD.
REQ-023 GET_CMD, GET_DATA and GET_CHK SHALL each consume one byte and advance; GET_CHK advances to EXEC.
REQ-024 EXEC SHALL last one cycle: it checks CHK and op, performs any register write only when STATUS=0x00, pulses frame_ok only when STATUS=0x00, and increments err_cnt only when STATUS!=0x00.
REQ-025 Latency: if the CHK byte is popped in cycle N, EXEC occurs in cycle N+1 and the first wr_uart occurs no earlier than cycle N+2.
REQ-026 SEND SHALL push response bytes 0..3 in order, one per cycle in which tx_full=0.
REQ-027 While tx_full=1, wr_uart SHALL be 0 and the byte index SHALL hold.
REQ-028 After byte 3 is pushed, the FSM SHALL return to HUNT.
REQ-029 rd_uart SHALL be 0 in EXEC and SEND; no RX bytes are consumed while a response is pending.
REQ-030 The timeout counter SHALL reset on every consumed byte and count while in GET_CMD, GET_DATA or GET_CHK with rx_empty=1.
REQ-031 When the timeout counter reaches TIMEOUT, the FSM SHALL go to HUNT, err_cnt SHALL increment, and no response SHALL be sent.
REQ-032 err_cnt SHALL saturate at 0xFF.
REQ-033 rd_uart and wr_uart SHALL never both be asserted in the same cycle.
REQ-034 Outputs rd_uart, wr_uart and w_data SHALL be registered.

Reset
REQ-035 Reset assertion SHALL force, from any state including mid-frame or mid-SEND: state=HUNT, reg_q=0, err_cnt=0, rd_uart=0, wr_uart=0, w_data=0, frame_ok=0, busy=0, timeout counter=0.
REQ-036 A response interrupted by reset SHALL NOT be resumed after reset deasserts.

Structure
REQ-037 A shared package uart_cmd_pkg SHALL hold: SYNC byte, op codes, status codes, the state encoding, and the response length.
REQ-038 The register file SHALL be the sub-module uart_cmd_regfile: 4x8, one write port, one async read port, active-low asynchronous reset.

Verification
REQ-039 Write: push A5 02 3C 3E -> reg_q[23:16]=0x3C; frame_ok pulses once; response A5 00 3C 3C.
REQ-040 Read: following the write, push A5 42 00 42 -> response A5 00 3C 3C; reg_q unchanged.
REQ-041 Error frames: push A5 02 3C 00 -> response A5 E1 00 E1, reg[2] unchanged, err_cnt=1; then push A5 C0 11 D1 -> response A5 E2 00 E2, err_cnt=2.
REQ-042 Junk and timeout: push 00 FF A5 02, then idle TIMEOUT cycles -> no wr_uart, FSM in HUNT, err_cnt incremented; then push A5 81 5A DB -> response A5 00 5A 5A.
REQ-043 Backpressure: hold tx_full=1 across EXEC for 10 cycles -> no wr_uart and rd_uart=0 throughout; on release, 4 consecutive pushes in order.
REQ-044 Reset: assert reset during SEND byte 1 -> all outputs at reset values immediately; after release, the next valid frame gets a correct full response.
